mbist_march_fsm: RTL and testbench

- March-algorithm sequencer that sits directly upstream of the MBIST address generator.
- Drives the generator's run, updown and scan_load inputs, and consumes its last_addr output.
- Issues one memory operation per cycle (chip-select, write-enable, data-background polarity) and a compare strobe with expected polarity to the downstream comparator.
- Executes a fixed March C- sequence, then reports done and pass/fail.

---
 rtl/mbist_pkg.sv | 51 +++++
 rtl/mbist_march_rom.sv | 40 ++++
 rtl/mbist_march_fsm.sv | 150 +++++++++++++++
 tb/tb_mbist_march_fsm.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/mbist_pkg.sv
// mbist_pkg: shared types and the March C- element table for the MBIST sequencer.
// Revision 1.0
`default_nettype none

package mbist_pkg;

  localparam int MARCH_ELEM_CNT = 6;

  // bit 1 marks a read, bit 0 carries the data-background polarity
  typedef enum logic [1:0] {
    OP_W0 = 2'b00,
    OP_W1 = 2'b01,
    OP_R0 = 2'b10,
    OP_R1 = 2'b11
  } op_e;

  typedef struct packed {
    logic          dir;     // 1 = ascending addresses
    logic [1:0]    op_cnt;
    op_e  [0:1]    op;
  } elem_t;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_RUN   = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4,
    ST_FAIL  = 3'd5
  } state_e;

  localparam elem_t MARCH_C_TABLE [MARCH_ELEM_CNT] = '{
    '{dir: 1'b1, op_cnt: 2'd1, op: '{OP_W0, OP_W0}},
    '{dir: 1'b1, op_cnt: 2'd2, op: '{OP_R0, OP_W1}},
    '{dir: 1'b1, op_cnt: 2'd2, op: '{OP_R1, OP_W0}},
    '{dir: 1'b0, op_cnt: 2'd2, op: '{OP_R0, OP_W1}},
    '{dir: 1'b0, op_cnt: 2'd2, op: '{OP_R1, OP_W0}},
    '{dir: 1'b0, op_cnt: 2'd1, op: '{OP_R0, OP_R0}}
  };

  function automatic logic op_is_read(input op_e op);
    return op[1];
  endfunction

  function automatic logic op_data(input op_e op);
    return op[0];
  endfunction

endpackage

`default_nettype wire

// File: rtl/mbist_march_rom.sv
// mbist_march_rom: combinational March C- lookup from (element, op) indices.
// Revision 1.0
`default_nettype none

module mbist_march_rom
  import mbist_pkg::*;
(
  input  logic [2:0] elem_idx,
  input  logic       op_idx,
  output op_e        op,
  output logic       dir,
  output logic       is_last_op,
  output logic       next_dir,
  output logic       is_last_elem
);

  elem_t cur;
  elem_t nxt;

  always_comb begin
    cur = MARCH_C_TABLE[0];
    for (int i = 0; i < MARCH_ELEM_CNT; i++) begin
      if (elem_idx == 3'(i)) cur = MARCH_C_TABLE[i];
    end
    // the final element has no successor; reuse its own direction
    nxt = cur;
    for (int i = 0; i < MARCH_ELEM_CNT - 1; i++) begin
      if (elem_idx == 3'(i)) nxt = MARCH_C_TABLE[i+1];
    end
  end

  assign op           = cur.op[op_idx];
  assign dir          = cur.dir;
  assign is_last_op   = ({1'b0, op_idx} == (cur.op_cnt - 2'd1));
  assign next_dir     = nxt.dir;
  assign is_last_elem = (elem_idx == 3'(MARCH_ELEM_CNT - 1));

endmodule

`default_nettype wire

// File: rtl/mbist_march_fsm.sv
// mbist_march_fsm: March C- sequencer driving the address generator, memory and comparator.
// Revision 1.0
`default_nettype none

module mbist_march_fsm
  import mbist_pkg::*;
#(
  parameter int BIST_CMP_LAT     = 2,
  parameter bit BIST_STOP_ON_ERR = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       bist_en,
  input  logic       bist_start,
  input  logic       last_addr,
  input  logic       bist_err,
  output logic       bist_run,
  output logic       bist_updown,
  output logic       bist_load,
  output logic       mem_cs,
  output logic       mem_we,
  output logic       mem_wpol,
  output logic       cmp_en,
  output logic       cmp_exp_pol,
  output logic       bist_busy,
  output logic       bist_done,
  output logic       bist_fail,
  output logic [2:0] fail_elem
);

  localparam int DRAIN_W = (BIST_CMP_LAT > 1) ? $clog2(BIST_CMP_LAT) : 1;

  state_e             state;
  logic [2:0]         elem_idx;
  logic               op_idx;
  logic [DRAIN_W-1:0] drain_cnt;
  logic               done_q;
  logic               fail_q;
  logic [2:0]         fail_elem_q;

  op_e  cur_op;
  logic cur_dir;
  logic is_last_op;
  logic next_dir;
  logic is_last_elem;

  mbist_march_rom u_rom (
    .elem_idx     (elem_idx),
    .op_idx       (op_idx),
    .op           (cur_op),
    .dir          (cur_dir),
    .is_last_op   (is_last_op),
    .next_dir     (next_dir),
    .is_last_elem (is_last_elem)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      elem_idx    <= '0;
      op_idx      <= 1'b0;
      drain_cnt   <= '0;
      done_q      <= 1'b0;
      fail_q      <= 1'b0;
      fail_elem_q <= '0;
    end else if (!bist_en) begin
      state     <= ST_IDLE;
      elem_idx  <= '0;
      op_idx    <= 1'b0;
      drain_cnt <= '0;
      done_q    <= 1'b0;
      fail_q    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE, ST_FAIL: begin
          if (bist_start) begin
            state       <= ST_LOAD;
            elem_idx    <= '0;
            op_idx      <= 1'b0;
            drain_cnt   <= '0;
            done_q      <= 1'b0;
            fail_q      <= 1'b0;
            fail_elem_q <= '0;
          end
        end
        ST_LOAD: state <= ST_RUN;
        ST_RUN: begin
          if (bist_err && !fail_q) begin
            fail_q      <= 1'b1;
            fail_elem_q <= elem_idx;
          end
          if (bist_err && BIST_STOP_ON_ERR) begin
            state  <= ST_FAIL;
            done_q <= 1'b1;
          end else if (is_last_op) begin
            op_idx <= 1'b0;
            if (last_addr) begin
              if (is_last_elem) state <= ST_DRAIN;
              else              elem_idx <= elem_idx + 3'd1;
            end
          end else begin
            op_idx <= 1'b1;
          end
        end
        ST_DRAIN: begin
          // reads still in the comparator pipeline can flag errors here
          if (bist_err && !fail_q) begin
            fail_q      <= 1'b1;
            fail_elem_q <= elem_idx;
          end
          if (bist_err && BIST_STOP_ON_ERR) begin
            state     <= ST_FAIL;
            done_q    <= 1'b1;
            drain_cnt <= '0;
          end else if (drain_cnt == DRAIN_W'(BIST_CMP_LAT - 1)) begin
            state     <= ST_DONE;
            done_q    <= 1'b1;
            drain_cnt <= '0;
          end else begin
            drain_cnt <= drain_cnt + 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  logic in_run;
  assign in_run = (state == ST_RUN);

  assign mem_cs      = in_run;
  assign mem_we      = in_run & ~op_is_read(cur_op);
  assign mem_wpol    = in_run & ~op_is_read(cur_op) & op_data(cur_op);
  assign cmp_en      = in_run & op_is_read(cur_op);
  assign cmp_exp_pol = in_run & op_is_read(cur_op) & op_data(cur_op);
  assign bist_updown = in_run ? cur_dir : 1'b1;
  assign bist_load   = (state == ST_LOAD);
  assign bist_busy   = (state == ST_LOAD) | (state == ST_RUN) | (state == ST_DRAIN);

  // at the boundary: hold on a direction change or after the final element
  assign bist_run = in_run & is_last_op &
                    (~last_addr | (~is_last_elem & (next_dir == cur_dir)));

  assign bist_done = done_q;
  assign bist_fail = fail_q;
  assign fail_elem = fail_elem_q;

endmodule

`default_nettype wire

// File: tb/tb_mbist_march_fsm.sv
// tb_mbist_march_fsm: directed scoreboard bench for the March C- sequencer.
// Revision 1.0
`default_nettype none

module tb_mbist_march_fsm;

  logic clk = 1'b0;
  logic rst, bist_en, bist_start, bist_err;
  always #5 clk = ~clk;

  logic last_a, run_a, upd_a, load_a, cs_a, we_a, wpol_a, cmp_a, exp_a, busy_a, done_a, fail_a;
  logic last_b, run_b, upd_b, load_b, cs_b, we_b, wpol_b, cmp_b, exp_b, busy_b, done_b, fail_b;
  logic [2:0] fe_a, fe_b;

  mbist_march_fsm #(.BIST_CMP_LAT(2), .BIST_STOP_ON_ERR(1'b1)) dut_a (
    .clk(clk), .rst(rst), .bist_en(bist_en), .bist_start(bist_start),
    .last_addr(last_a), .bist_err(bist_err), .bist_run(run_a), .bist_updown(upd_a),
    .bist_load(load_a), .mem_cs(cs_a), .mem_we(we_a), .mem_wpol(wpol_a),
    .cmp_en(cmp_a), .cmp_exp_pol(exp_a), .bist_busy(busy_a), .bist_done(done_a),
    .bist_fail(fail_a), .fail_elem(fe_a));

  mbist_march_fsm #(.BIST_CMP_LAT(2), .BIST_STOP_ON_ERR(1'b0)) dut_b (
    .clk(clk), .rst(rst), .bist_en(bist_en), .bist_start(bist_start),
    .last_addr(last_b), .bist_err(bist_err), .bist_run(run_b), .bist_updown(upd_b),
    .bist_load(load_b), .mem_cs(cs_b), .mem_we(we_b), .mem_wpol(wpol_b),
    .cmp_en(cmp_b), .cmp_exp_pol(exp_b), .bist_busy(busy_b), .bist_done(done_b),
    .bist_fail(fail_b), .fail_elem(fe_b));

  // address generator models: start_addr = 0, wrap at both boundaries
  int depth = 4;
  int addr_a = 0;
  int addr_b = 0;

  always @(posedge clk) begin
    if (rst || load_a) addr_a <= 0;
    else if (run_a)    addr_a <= upd_a ? ((addr_a == depth - 1) ? 0 : addr_a + 1)
                                       : ((addr_a == 0) ? depth - 1 : addr_a - 1);
    if (rst || load_b) addr_b <= 0;
    else if (run_b)    addr_b <= upd_b ? ((addr_b == depth - 1) ? 0 : addr_b + 1)
                                       : ((addr_b == 0) ? depth - 1 : addr_b - 1);
  end

  assign last_a = upd_a ? (addr_a == depth - 1) : (addr_a == 0);
  assign last_b = upd_b ? (addr_b == depth - 1) : (addr_b == 0);

  typedef struct packed {
    logic       we;
    logic       rd;
    logic       pol;
    logic [3:0] addr;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   passes = 0;
  int   fails  = 0;
  int   runs_a = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // March C- expectation: ops as {read, data}, element directions, op counts
  task automatic push_trace();
    int         n_ops [6];
    logic       up    [6];
    logic [1:0] ops   [6][2];
    exp_t       e;
    int         a;
    n_ops = '{1, 2, 2, 2, 2, 1};
    up    = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    ops   = '{'{2'b00, 2'b00}, '{2'b10, 2'b01}, '{2'b11, 2'b00},
              '{2'b10, 2'b01}, '{2'b11, 2'b00}, '{2'b10, 2'b10}};
    for (int m = 0; m < 6; m++) begin
      for (int k = 0; k < depth; k++) begin
        a = up[m] ? k : depth - 1 - k;
        for (int j = 0; j < n_ops[m]; j++) begin
          e.we   = ~ops[m][j][1];
          e.rd   = ops[m][j][1];
          e.pol  = ops[m][j][0];
          e.addr = 4'(a);
          sb.push_back(e);
        end
      end
    end
  endtask

  task automatic run_ops(input bit sel, input int n);
    exp_t       e;
    logic [7:0] obs;
    for (int i = 0; i < n; i++) begin
      if (sb.size() == 0) begin
        check("sb_underflow", 32'(sb.size()), 32'd1);
      end else begin
        e = sb.pop_front();
        if (!sel) obs = {cs_a, we_a, cmp_a, (we_a ? wpol_a : exp_a), 4'(addr_a)};
        else      obs = {cs_b, we_b, cmp_b, (we_b ? wpol_b : exp_b), 4'(addr_b)};
        if (!sel && run_a) runs_a++;
        check(sel ? "op_b" : "op_a", 32'(obs), 32'({1'b1, e.we, e.rd, e.pol, e.addr}));
      end
      @(negedge clk);
    end
  endtask

  task automatic start_run();
    bist_en = 1'b0;
    @(negedge clk);
    bist_en    = 1'b1;
    bist_start = 1'b1;
    @(negedge clk);
    bist_start = 1'b0;
    sb.delete();
    push_trace();
  endtask

  initial begin
    rst = 1'b1; bist_en = 1'b0; bist_start = 1'b0; bist_err = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("reset", 32'({busy_a, done_a, fail_a, upd_a, cs_a, we_a, cmp_a, load_a, run_a, fe_a}),
          32'({1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0}));

    // normal run, 4 addresses
    start_run();
    check("load", 32'({load_a, busy_a, run_a, cs_a}), 32'(4'b1100));
    @(negedge clk);
    check("load_once", 32'(load_a), 32'd0);
    run_ops(1'b0, 19);
    check("hold_m2_m3", 32'({run_a, 4'(addr_a)}), 32'({1'b0, 4'd3}));
    run_ops(1'b0, 21);
    check("run_pulses", 32'(runs_a), 32'd22);
    check("drain1", 32'({cs_a, busy_a, done_a}), 32'(3'b010));
    @(negedge clk);
    check("drain2", 32'({cs_a, busy_a, done_a}), 32'(3'b010));
    @(negedge clk);
    check("done", 32'({busy_a, done_a, fail_a}), 32'(3'b010));
    check("sb_empty", 32'(sb.size()), 32'd0);

    // error during M3 aborts the stop-on-error instance
    start_run();
    @(negedge clk);
    run_ops(1'b0, 22);
    bist_err = 1'b1;
    run_ops(1'b0, 1);
    bist_err = 1'b0;
    check("abort", 32'({fail_a, done_a, cs_a, busy_a, fe_a}), 32'({4'b1100, 3'd3}));

    // errors in M1 and M4 on the run-to-completion instance
    start_run();
    @(negedge clk);
    run_ops(1'b1, 5);
    bist_err = 1'b1;
    run_ops(1'b1, 1);
    bist_err = 1'b0;
    check("sticky", 32'({fail_b, fe_b}), 32'({1'b1, 3'd1}));
    run_ops(1'b1, 24);
    bist_err = 1'b1;
    run_ops(1'b1, 1);
    bist_err = 1'b0;
    run_ops(1'b1, 9);
    check("cont_drain", 32'({busy_b, cs_b, done_b, fail_b}), 32'(4'b1001));
    repeat (2) @(negedge clk);
    check("cont_done", 32'({busy_b, done_b, fail_b, fe_b}), 32'({3'b011, 3'd1}));

    // bist_en dropped mid-run
    start_run();
    @(negedge clk);
    run_ops(1'b0, 10);
    bist_en = 1'b0;
    @(negedge clk);
    check("en_low", 32'({busy_a, cs_a, we_a, cmp_a, run_a, load_a, done_a, fail_a}), 32'd0);
    bist_en = 1'b1;

    // start ignored while busy, then reset during drain
    start_run();
    @(negedge clk);
    run_ops(1'b0, 5);
    bist_start = 1'b1;
    run_ops(1'b0, 1);
    bist_start = 1'b0;
    run_ops(1'b0, 34);
    check("drain_pre_rst", 32'({busy_a, cs_a}), 32'(2'b10));
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_drain", 32'({busy_a, done_a, fail_a, upd_a, cs_a, we_a, cmp_a, load_a, run_a, fe_a}),
          32'({1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0}));

    // single address: every same-direction element boundary wraps onto itself
    depth = 1;
    start_run();
    @(negedge clk);
    runs_a = 0;
    run_ops(1'b0, 10);
    check("d1_runs", 32'(runs_a), 32'd4);
    check("d1_drain", 32'({busy_a, cs_a}), 32'(2'b10));
    repeat (2) @(negedge clk);
    check("d1_done", 32'({busy_a, done_a, fail_a}), 32'(3'b010));

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

`default_nettype wire
